// File: rtl/pick_slot_buffer_pkg.sv
// Shared definitions for the pick_slot_buffer slice: parameter defaults,
// the slot-index width helper and a slot-index type for the default size.
package pick_slot_buffer_pkg;

    localparam int DEF_NUM_ENTRIES = 8;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_NUM_SEL     = 2;
    localparam int DEF_DIR_L2H     = 1;

    // Index width for n slots; never narrower than one bit.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_SLOT_W = slot_w(DEF_NUM_ENTRIES);

    typedef logic [DEF_SLOT_W-1:0] slot_idx_t;

endpackage

// File: rtl/generic_ffs_N.sv
// Multi-select find-first: picks up to NUM_SEL set bits of req_in in priority
// order (DIR_L2H=1: lowest index first) and returns, per lane, a valid flag,
// a one-hot grant, the encoded index and the matching data word.
// An empty lane reports the default index (lowest-priority end's opposite,
// i.e. the first index scanned) and that slot's data.
module generic_ffs_N
    import pick_slot_buffer_pkg::*;
#(
    parameter int WIDTH      = DEF_NUM_ENTRIES,
    parameter int SIZE       = DEF_SLOT_W,
    parameter int NUM_SEL    = DEF_NUM_SEL,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DIR_L2H    = DEF_DIR_L2H
) (
    input  logic [WIDTH-1:0]            req_in,
    input  logic [WIDTH*DATA_WIDTH-1:0] data_in,
    output logic [NUM_SEL-1:0]          req_sum,
    output logic [NUM_SEL*WIDTH-1:0]    req_out,
    output logic [NUM_SEL*SIZE-1:0]     enc_req_out,
    output logic [NUM_SEL*DATA_WIDTH-1:0] data_out
);

    localparam int DEFAULT_IDX = (DIR_L2H != 0) ? 0 : WIDTH - 1;

    // Successive find-first passes, each masking off the previous winner.
    always_comb begin : select_lanes
        logic [WIDTH-1:0] remaining;
        logic             found;
        int               pick;
        int               j;
        remaining   = req_in;
        req_sum     = '0;
        req_out     = '0;
        enc_req_out = '0;
        data_out    = '0;
        found       = 1'b0;
        pick        = DEFAULT_IDX;
        j           = 0;
        for (int s = 0; s < NUM_SEL; s++) begin
            found = 1'b0;
            pick  = DEFAULT_IDX;
            for (int k = 0; k < WIDTH; k++) begin
                j = (DIR_L2H != 0) ? k : (WIDTH - 1 - k);
                if (!found && remaining[j]) begin
                    found = 1'b1;
                    pick  = j;
                end
            end
            req_sum[s] = found;
            if (found) begin
                remaining[pick]          = 1'b0;
                req_out[s*WIDTH + pick]  = 1'b1;
            end
            enc_req_out[s*SIZE +: SIZE]             = SIZE'(pick);
            data_out[s*DATA_WIDTH +: DATA_WIDTH]    = data_in[pick*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/pick_slot_buffer.sv
// Unordered slot buffer for trace/debug records. Records enter one per cycle
// and land in the first free slot; up to NUM_SEL valid slots are presented on
// parallel lanes in slot-index priority order (not arrival order).
// Optional feature macro: SLOT_BUF_STATS_EN adds an occupancy high-water mark.
//
// Handshakes: a transfer happens on a lane/input exactly when valid && ready
// are both high at a rising edge. valid never depends on ready; out_valid,
// out_data, out_slot and in_ready are driven from registers only.
module pick_slot_buffer
    import pick_slot_buffer_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_SEL     = DEF_NUM_SEL,
    parameter int DIR_L2H     = DEF_DIR_L2H,
    localparam int SLOT_W     = slot_w(NUM_ENTRIES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic [NUM_SEL-1:0]            out_valid,
    input  logic [NUM_SEL-1:0]            out_ready,
    output logic [NUM_SEL*DATA_WIDTH-1:0] out_data,
    output logic [NUM_SEL*SLOT_W-1:0]     out_slot,
    output logic [SLOT_W:0]               occupancy,
`ifdef SLOT_BUF_STATS_EN
    output logic [SLOT_W:0]               occupancy_hwm,
`endif
    output logic                          full,
    output logic                          empty
);

    localparam int OCC_W = SLOT_W + 1;

    logic [NUM_ENTRIES-1:0]            slot_vld;
    logic [NUM_ENTRIES*DATA_WIDTH-1:0] slot_data;
    logic [OCC_W-1:0]                  occ_q;

    logic [NUM_SEL*NUM_ENTRIES-1:0]    grant;
    logic [NUM_ENTRIES-1:0]            rel_mask;
    logic [OCC_W-1:0]                  rel_cnt;
    logic [NUM_ENTRIES-1:0]            alloc_oh;
    logic [SLOT_W-1:0]                 alloc_idx;
    logic                              alloc;
    logic [OCC_W-1:0]                  occ_upd;
    logic [OCC_W-1:0]                  occ_next;

    assign full      = (occ_q == OCC_W'(NUM_ENTRIES));
    assign empty     = (occ_q == '0);
    assign in_ready  = ~full;
    assign occupancy = occ_q;
    assign alloc     = in_valid & in_ready;

    generic_ffs_N #(
        .WIDTH      (NUM_ENTRIES),
        .SIZE       (SLOT_W),
        .NUM_SEL    (NUM_SEL),
        .DATA_WIDTH (DATA_WIDTH),
        .DIR_L2H    (DIR_L2H)
    ) u_ffs (
        .req_in      (slot_vld),
        .data_in     (slot_data),
        .req_sum     (out_valid),
        .req_out     (grant),
        .enc_req_out (out_slot),
        .data_out    (out_data)
    );

    // First free slot in priority order, taken from the registered valid bits.
    always_comb begin : free_search
        logic found;
        int   j;
        found     = 1'b0;
        j         = 0;
        alloc_oh  = '0;
        alloc_idx = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            j = (DIR_L2H != 0) ? k : (NUM_ENTRIES - 1 - k);
            if (!found && !slot_vld[j]) begin
                found       = 1'b1;
                alloc_idx   = SLOT_W'(j);
                alloc_oh[j] = alloc;
            end
        end
    end

    // Slots released by completed lane handshakes, and how many there are.
    always_comb begin : release_calc
        rel_mask = '0;
        rel_cnt  = '0;
        for (int s = 0; s < NUM_SEL; s++) begin
            if (out_valid[s] && out_ready[s]) begin
                rel_mask = rel_mask | grant[s*NUM_ENTRIES +: NUM_ENTRIES];
                rel_cnt  = rel_cnt + OCC_W'(1);
            end
        end
    end

    // Occupancy after this edge; flush empties the buffer regardless of traffic.
    always_comb begin : occ_calc
        occ_upd  = occ_q + OCC_W'(alloc) - rel_cnt;
        occ_next = flush ? '0 : occ_upd;
    end

    // Slot valid bits and occupancy; reset dominates flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_vld <= '0;
            occ_q    <= '0;
        end else if (flush) begin
            slot_vld <= '0;
            occ_q    <= '0;
        end else begin
            slot_vld <= (slot_vld & ~rel_mask) | alloc_oh;
            occ_q    <= occ_upd;
        end
    end

    // Payload storage is written on every accepted record and never reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            slot_data[alloc_idx*DATA_WIDTH +: DATA_WIDTH] <= in_data;
        end
    end

`ifdef SLOT_BUF_STATS_EN
    // High-water mark of occupancy; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_hwm <= '0;
        end else if (occ_next > occupancy_hwm) begin
            occupancy_hwm <= occ_next;
        end
    end
`endif

endmodule

// File: tb/tb_pick_slot_buffer.sv
// Self-checking bench for pick_slot_buffer (default parameters, DIR_L2H=1).
// Reference model: a plain array of slots; lanes are the first NUM_SEL valid
// slot indices listed in priority order. SLOT_BUF_STATS_EN also checks the HWM.
module tb_pick_slot_buffer;
    import pick_slot_buffer_pkg::*;

    localparam int NE  = 8;
    localparam int DW  = 32;
    localparam int NS  = 2;
    localparam int SW  = 3;
    localparam int OW  = 4;
    localparam int DIR = 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [NS-1:0]  out_valid;
    logic [NS-1:0]  out_ready;
    logic [NS*DW-1:0] out_data;
    logic [NS*SW-1:0] out_slot;
    logic [OW-1:0]  occupancy;
    logic           full;
    logic           empty;
`ifdef SLOT_BUF_STATS_EN
    logic [OW-1:0]  occupancy_hwm;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic          m_vld [NE];
    logic [DW-1:0] m_data[NE];
    int            m_hwm;
    int            sel_q[$];
    logic [DW-1:0] exp_q[$];

    pick_slot_buffer #(
        .NUM_ENTRIES (NE),
        .DATA_WIDTH  (DW),
        .NUM_SEL     (NS),
        .DIR_L2H     (DIR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_slot      (out_slot),
        .occupancy     (occupancy),
`ifdef SLOT_BUF_STATS_EN
        .occupancy_hwm (occupancy_hwm),
`endif
        .full          (full),
        .empty         (empty)
    );

    // Clock
    always #5 clk = ~clk;

    // Valid slots in priority order, with their payloads.
    function automatic void fill_sel();
        int idx;
        sel_q.delete();
        exp_q.delete();
        for (int k = 0; k < NE; k++) begin
            idx = (DIR != 0) ? k : NE - 1 - k;
            if (m_vld[idx]) begin
                sel_q.push_back(idx);
                exp_q.push_back(m_data[idx]);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every visible output against the model.
    task automatic check_all(input string tag);
        int cnt;
        logic [NS-1:0] ev;
        fill_sel();
        cnt = sel_q.size();
        ev  = '0;
        for (int i = 0; i < NS; i++) ev[i] = (i < cnt);
        chk({tag, "/out_valid"}, DW'(out_valid), DW'(ev));
        chk({tag, "/occupancy"}, DW'(occupancy), DW'(cnt));
        chk({tag, "/full"}, DW'(full), DW'(cnt == NE));
        chk({tag, "/empty"}, DW'(empty), DW'(cnt == 0));
        chk({tag, "/in_ready"}, DW'(in_ready), DW'(cnt != NE));
        for (int i = 0; i < NS; i++) begin
            if (ev[i]) begin
                chk({tag, "/lane_data"}, out_data[i*DW +: DW], exp_q[i]);
                chk({tag, "/lane_slot"}, DW'(out_slot[i*SW +: SW]), DW'(sel_q[i]));
            end
        end
`ifdef SLOT_BUF_STATS_EN
        chk({tag, "/hwm"}, DW'(occupancy_hwm), DW'(m_hwm));
`endif
    endtask

    // Apply the effect of the coming clock edge to the model.
    task automatic model_edge();
        int  cnt;
        int  fr;
        int  idx;
        bit  acc;
        fill_sel();
        cnt = sel_q.size();
        acc = in_valid && (cnt < NE);
        fr  = -1;
        for (int k = 0; k < NE; k++) begin
            idx = (DIR != 0) ? k : NE - 1 - k;
            if (fr < 0 && !m_vld[idx]) fr = idx;
        end
        if (reset || flush) begin
            for (int k = 0; k < NE; k++) m_vld[k] = 1'b0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (i < cnt && out_ready[i]) m_vld[sel_q[i]] = 1'b0;
            end
            if (acc) begin
                m_vld[fr]  = 1'b1;
                m_data[fr] = in_data;
            end
        end
        cnt = 0;
        for (int k = 0; k < NE; k++) cnt += int'(m_vld[k]);
        if (reset) m_hwm = 0;
        else if (cnt > m_hwm) m_hwm = cnt;
    endtask

    // Driver: one clock cycle with the currently applied inputs.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0;
        for (int k = 0; k < NE; k++) begin
            m_vld[k]  = 1'b0;
            m_data[k] = '0;
        end
        m_hwm = 0;
        cycle();
        cycle();
        reset = 1'b0;
        check_all("reset");

        // Three writes land in slots 0, 1, 2
        in_valid = 1'b1;
        in_data = 32'hA000_000A; cycle();
        in_data = 32'hB000_000B; cycle();
        in_data = 32'hC000_000C; cycle();
        in_valid = 1'b0;
        check_all("abc");
        chk("abc/lane0_data", out_data[0 +: DW], 32'hA000_000A);
        chk("abc/lane1_slot", DW'(out_slot[SW +: SW]), 32'd1);

        // Accept lane1 only: lanes repack to A and C
        out_ready = 2'b10; cycle(); out_ready = '0;
        check_all("pop_lane1");
        chk("pop_lane1/lane1_slot", DW'(out_slot[SW +: SW]), 32'd2);

        // Next write reuses the freed slot 1
        in_valid = 1'b1; in_data = 32'hD000_000D; cycle(); in_valid = 1'b0;
        check_all("reuse");
        chk("reuse/lane1_data", out_data[DW +: DW], 32'hD000_000D);

        // Fill to capacity
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom; cycle();
        end
        check_all("full");
        chk("full/in_ready", DW'(in_ready), 32'd0);

        // Full: write blocked even though a lane releases
        in_data = $urandom; out_ready = 2'b01; cycle();
        in_valid = 1'b0; out_ready = '0;
        check_all("full_release");
        chk("full_release/occupancy", DW'(occupancy), 32'd7);

        // Drain to 5, then flush with write and both lanes handing off
        out_ready = 2'b11; cycle(); out_ready = '0;
        check_all("occ5");
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hE000_000E; out_ready = 2'b11;
        check_all("flush_cycle");
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = '0;
        check_all("post_flush");
        chk("post_flush/empty", DW'(empty), 32'd1);

        // Reset mid-operation with traffic active
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom; cycle();
        end
        check_all("occ4");
        reset = 1'b1; out_ready = 2'b11; in_data = $urandom; cycle();
        reset = 1'b0; in_valid = 1'b0; out_ready = '0;
        check_all("post_reset");
        chk("post_reset/out_valid", DW'(out_valid), 32'd0);

        // Randomized traffic: fill-heavy first half, drain-heavy second half
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) < ((i < 300) ? 3 : 1));
            in_data   = $urandom;
            out_ready = NS'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 59) == 0);
            check_all("rand");
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = '0;
        check_all("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pick_slot_buffer.md
# pick_slot_buffer

Buffers up to NUM_ENTRIES pending trace/debug records in an unordered slot array and presents up to NUM_SEL of them per cycle on parallel output lanes. It sits directly upstream of the multi-select find-first consumers: the slot valid vector is the request vector, and the slot payloads are the data vector, for an instance of `generic_ffs_N`. Records are accepted one per cycle with a valid/ready handshake; each output lane is drained independently with its own valid/ready handshake.

## Interface
Parameters:
- NUM_ENTRIES, 8: slot count; ≥ 2.
- DATA_WIDTH, 32: payload width.
- NUM_SEL, 2: output lanes; 1 ≤ NUM_SEL ≤ NUM_ENTRIES.
- DIR_L2H, 1: 1 = lowest slot index has priority; 0 = highest slot index has priority.
- SLOT_W, derived: `$clog2(NUM_ENTRIES)`, minimum 1.

Ports:
- clk  in  1  clock. The block has one clock.
- reset  in  1  reset; synchronous, active-high.
- flush  in  1  clears all slots at the next edge.
- in_valid  in  1  write request.
- in_ready  out  1  slot available; equals ~full.
- in_data  in  DATA_WIDTH  payload.
- out_valid  out  NUM_SEL  lane holds a selected slot.
- out_ready  in  NUM_SEL  lane consumer accepts.
- out_data  out  NUM_SEL×DATA_WIDTH  lane payload.
- out_slot  out  NUM_SEL×SLOT_W  slot index of the lane.
- occupancy  out  SLOT_W+1  number of valid slots.
- full, empty  out  1 each  occupancy == NUM_ENTRIES / == 0.
- occupancy_hwm  out  SLOT_W+1  present only when SLOT_BUF_STATS_EN is defined.

## Operation
- State: slot_vld[NUM_ENTRIES], slot_data[NUM_ENTRIES], occupancy register.
- Allocation: when in_valid && in_ready, in_data is written to the first free slot, found by priority on ~slot_vld in the DIR_L2H direction. Allocation uses the registered slot_vld only.
- Selection: combinational over the registered slot_vld and slot_data. Lane i shows the (i+1)-th valid slot in priority order. Lanes are contiguous: out_valid[i] implies out_valid[i-1].
- Ordering is by slot index, not by age. Consumers must not rely on FIFO order.
- Release: when out_valid[i] && out_ready[i], slot out_slot[i] clears at the next edge. Lanes release independently and in any combination.
- Simultaneous allocate and release: both take effect. A slot freed this cycle is not reallocated until the next cycle. occupancy_next = occupancy + alloc − popcount(release).
- When full, in_ready = 0, even if a release happens in the same cycle.
- Flush:
  - Lane handshakes in the flush cycle complete; consumers keep the data.
  - All slots clear and occupancy becomes 0 at the next edge.
  - in_ready is not gated by flush. An accepted write in the flush cycle is dropped.
- out_data/out_slot of an invalid lane: slot 0 (DIR_L2H=0: slot NUM_ENTRIES−1) and its data. Do not check these values.

## Timing
- Write at edge t → visible on out_valid at t+1.
- Release at edge t → slot invalid and lanes repacked at t+1.
- No combinational path from in_* or out_ready to out_valid, out_data or out_slot. in_ready depends only on registers.
- Reset values:
  - slot_vld, occupancy, out_valid: 0.
  - empty = 1, full = 0, in_ready = 1.
  - occupancy_hwm = 0.
  - slot_data is not reset.
- Reset mid-operation: all state clears at the edge and any in-flight handshakes are discarded. Reset dominates flush.

## Configuration
- SLOT_BUF_STATS_EN defined:
  - Adds the occupancy_hwm port and register.
  - The register updates to max(occupancy_hwm, occupancy_next) every cycle.
  - It is cleared by reset only; flush does not clear it.
- Not defined: no port and no register.

## Structure
- Shared package `pick_slot_buffer_pkg`: parameter defaults, and a slot-index typedef sized from NUM_ENTRIES.
- One sub-module: `generic_ffs_N` with WIDTH=NUM_ENTRIES, SIZE=SLOT_W, NUM_SEL=NUM_SEL.
  - req_sum → out_valid, data_out → out_data, enc_req_out → out_slot.
  - req_out (one-hot) is ANDed with out_ready to build the release mask.
- The free-slot search is an inline priority loop, not a second instance.

## Test plan
Defaults, DIR_L2H=1.
- Reset, then write A, B, C on consecutive cycles → slots 0, 1, 2. Cycle after C: out_valid=2'b11, lane0=(A, 0), lane1=(B, 1), occupancy=3.
- Accept lane1 only → next cycle lane0=(A, 0), lane1=(C, 2), occupancy=2. A write that cycle lands in slot 1.
- Fill 8 slots → full=1, in_ready=0. Then in_valid=1 with out_ready=2'b01 → no write, occupancy=7 next cycle, in_ready=1.
- Occupancy 5, flush=1 with in_valid=1 and out_ready=2'b11 → lanes hand off two records; next cycle occupancy=0, empty=1, out_valid=0; the written record is absent.
- With SLOT_BUF_STATS_EN: fill to 6, drain to 1, flush → occupancy_hwm=6 throughout. After reset, occupancy_hwm=0.
- Occupancy 4, assert reset with writes and handshakes active → next cycle occupancy=0, out_valid=0, in_ready=1.
